// File: rtl/nr4sdm_pkg.sv
// Shared defaults, FSM state encoding and decoded-digit type for the NR4SD-/MB decoder.
package nr4sdm_pkg;
  localparam int NUM_DIGITS_DEF = 15;
  localparam int WIDTH_DEF      = 2 * NUM_DIGITS_DEF + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // val is a 3-bit two's-complement digit in -2..2
  typedef struct packed {
    logic [2:0] val;
    logic       illegal;
  } digit_t;
endpackage

// File: rtl/nr4sdm_if.sv
// Digit-set request / result response bus between producer-consumer and decoder.
interface nr4sdm_if #(
  parameter int NUM_DIGITS = 15,
  parameter int WIDTH      = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [NUM_DIGITS-1:0] nm;
  logic [NUM_DIGITS-1:0] np;
  logic                  sign;
  logic                  one;
  logic                  two;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      a;
  logic                  err;

  modport master (
    output in_valid, nm, np, sign, one, two, out_ready,
    input  in_ready, out_valid, a, err
  );

  modport slave (
    input  in_valid, nm, np, sign, one, two, out_ready,
    output in_ready, out_valid, a, err
  );
endinterface

// File: rtl/nr4sdm_digit_dec.sv
// Combinational digit decoder: NR4SD- pair (nm,np) or Modified Booth (sign,one,two).
module nr4sdm_digit_dec
  import nr4sdm_pkg::*;
(
  input  logic   mb_mode,
  input  logic   nm,
  input  logic   np,
  input  logic   sign,
  input  logic   one,
  input  logic   two,
  output digit_t dig
);
  logic [2:0] mag;

  always_comb begin
    mag = 3'd0;
    dig = '0;
    if (mb_mode) begin
      // one&two is illegal and decodes as zero magnitude
      dig.illegal = one & two;
      if (one & ~two)      mag = 3'd1;
      else if (two & ~one) mag = 3'd2;
      dig.val = sign ? (3'd0 - mag) : mag;
    end else begin
      unique case ({nm, np})
        2'b01:   dig.val = 3'b001;
        2'b10:   dig.val = 3'b110;
        2'b11:   dig.val = 3'b111;
        default: dig.val = 3'b000;
      endcase
    end
  end
endmodule

// File: rtl/nr4sdm_decoder.sv
// Sequential NR4SD- to two's-complement decoder: Horner accumulation, one digit per cycle, MSB first.
module nr4sdm_decoder
  import nr4sdm_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int WIDTH      = WIDTH_DEF
) (
  input logic     clk,
  input logic     rst,
  nr4sdm_if.slave bus
);
  localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_e                state_q, state_d;
  logic [NUM_DIGITS-1:0] nm_q, nm_d;
  logic [NUM_DIGITS-1:0] np_q, np_d;
  logic [WIDTH-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_pend_q, err_pend_d;
  logic [WIDTH-1:0]      a_q, a_d;
  logic                  err_q, err_d;
  logic                  out_valid_q, out_valid_d;

  digit_t           mb_dig, run_dig;
  logic [WIDTH-1:0] mb_ext, run_ext;

  nr4sdm_digit_dec u_mb_dec (
    .mb_mode (1'b1),
    .nm      (1'b0),
    .np      (1'b0),
    .sign    (bus.sign),
    .one     (bus.one),
    .two     (bus.two),
    .dig     (mb_dig)
  );

  nr4sdm_digit_dec u_run_dec (
    .mb_mode (1'b0),
    .nm      (nm_q[cnt_q]),
    .np      (np_q[cnt_q]),
    .sign    (1'b0),
    .one     (1'b0),
    .two     (1'b0),
    .dig     (run_dig)
  );

  assign mb_ext  = {{(WIDTH-3){mb_dig.val[2]}},  mb_dig.val};
  assign run_ext = {{(WIDTH-3){run_dig.val[2]}}, run_dig.val};

  always_comb begin
    state_d     = state_q;
    nm_d        = nm_q;
    np_d        = np_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    err_pend_d  = err_pend_q;
    a_d         = a_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          nm_d       = bus.nm;
          np_d       = bus.np;
          acc_d      = mb_ext;
          cnt_d      = CNT_W'(NUM_DIGITS - 1);
          err_pend_d = mb_dig.illegal;
          state_d    = RUN;
        end
      end
      RUN: begin
        acc_d = (acc_q << 2) + run_ext;
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE: begin
        // first DONE cycle publishes the result into the output register
        if (!out_valid_q) begin
          a_d         = acc_q;
          err_d       = err_pend_q;
          out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      nm_q        <= '0;
      np_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      err_pend_q  <= 1'b0;
      a_q         <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      nm_q        <= nm_d;
      np_q        <= np_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      err_pend_q  <= err_pend_d;
      a_q         <= a_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.a         = a_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_nr4sdm_decoder.sv
// Randomized self-checking bench for nr4sdm_decoder against a digit-weight-sum model.
module tb_nr4sdm_decoder;
  import nr4sdm_pkg::*;

  localparam int ND  = NUM_DIGITS_DEF;
  localparam int W   = WIDTH_DEF;
  localparam int LAT = ND + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nr4sdm_if #(.NUM_DIGITS(ND), .WIDTH(W)) bus ();

  nr4sdm_decoder #(.NUM_DIGITS(ND), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Value = sum of digit * weight, computed with wide integer arithmetic, mod 2^W
  function automatic logic [W-1:0] ref_value(input logic [ND-1:0] nm, input logic [ND-1:0] np,
                                             input logic s, input logic o, input logic t);
    longint sum;
    longint mag;
    sum = 0;
    for (int j = 0; j < ND; j++)
      sum += (longint'(np[j]) - 2 * longint'(nm[j])) * (longint'(1) << (2 * j));
    mag = (o && t) ? 0 : o ? 1 : t ? 2 : 0;
    sum += (s ? -mag : mag) * (longint'(1) << (2 * ND));
    return sum[W-1:0];
  endfunction

  // Reference NR4SD- encoder: radix-4 digits in {-2..1} with carry, MB digit on top
  task automatic encode(input logic [W-1:0] x, output logic [ND-1:0] nm, output logic [ND-1:0] np,
                        output logic s, output logic o, output logic t);
    int c, tt, top;
    c = 0; nm = '0; np = '0;
    for (int j = 0; j < ND; j++) begin
      tt = int'(x[2*j +: 2]) + c;
      case (tt)
        1: np[j] = 1'b1;
        2: nm[j] = 1'b1;
        3: begin nm[j] = 1'b1; np[j] = 1'b1; end
        default: ;
      endcase
      c = (tt >= 2) ? 1 : 0;
    end
    top = (x[W-1] ? -2 : 0) + (x[W-2] ? 1 : 0) + c;
    s = (top < 0) ? 1'b1 : (top == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    o = (top == 1) || (top == -1);
    t = (top == 2) || (top == -2);
  endtask

  task automatic run_txn(input logic [ND-1:0] nm, input logic [ND-1:0] np,
                         input logic s, input logic o, input logic t,
                         output logic [W-1:0] a, output logic e, output int lat);
    @(negedge clk);
    bus.nm = nm; bus.np = np; bus.sign = s; bus.one = o; bus.two = t;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.nm = ND'($urandom); bus.np = ND'($urandom);
    bus.sign = 1'($urandom); bus.one = 1'($urandom); bus.two = 1'($urandom);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    a = bus.a;
    e = bus.err;
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    #1;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.a !== '0) begin miscompares++; $display("FAIL reset_a: got %h want 0", bus.a); end
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", bus.err); end
  endtask

  task automatic test_vectors();
    logic [ND-1:0] tnm [4] = '{15'h0, 15'h0001, 15'h0, 15'h0};
    logic [ND-1:0] tnp [4] = '{15'h0, 15'h0001, 15'h0, 15'h0};
    logic          ts  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic          to  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic          tt  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [W-1:0]  ta  [4] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h4000_0000};
    logic [W-1:0]  a;
    logic          e;
    int            lat;
    for (int i = 0; i < 4; i++) begin
      run_txn(tnm[i], tnp[i], ts[i], to[i], tt[i], a, e, lat);
      vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, LAT); end
      vectors++; if (a !== ta[i]) begin miscompares++; $display("FAIL vec%0d_a: got %h want %h", i, a, ta[i]); end
      vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL vec%0d_err: got %b want 0", i, e); end
      release_out();
    end
  endtask

  task automatic test_illegal();
    logic [W-1:0]  a;
    logic          e;
    int            lat;
    logic [ND-1:0] nm, np;
    run_txn(ND'($urandom), ND'($urandom), 1'($urandom), 1'b1, 1'b1, a, e, lat);
    vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL illegal_err: got %b want 1", e); end
    vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL illegal_latency: got %0d want %0d", lat, LAT); end
    release_out();
    nm = ND'($urandom); np = ND'($urandom);
    run_txn(nm, np, 1'b1, 1'b1, 1'b0, a, e, lat);
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL illegal_next_err: got %b want 0", e); end
    vectors++; if (a !== ref_value(nm, np, 1'b1, 1'b1, 1'b0)) begin
      miscompares++; $display("FAIL illegal_next_a: got %h want %h", a, ref_value(nm, np, 1'b1, 1'b1, 1'b0)); end
    release_out();
  endtask

  task automatic test_backpressure();
    logic [W-1:0]  a, exp;
    logic          e;
    int            lat;
    logic [ND-1:0] nm, np;
    nm = ND'($urandom); np = ND'($urandom);
    exp = ref_value(nm, np, 1'b0, 1'b0, 1'b1);
    run_txn(nm, np, 1'b0, 1'b0, 1'b1, a, e, lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.a !== exp || bus.in_ready !== 1'b0 || bus.err !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold: got ov=%b a=%h ir=%b err=%b want ov=1 a=%h ir=0 err=0",
                 bus.out_valid, bus.a, bus.in_ready, bus.err, exp);
      end
    end
    release_out();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL stall_release: got ov=%b ir=%b want ov=0 ir=1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0]  a;
    logic          e;
    int            lat;
    bit            seen;
    logic [ND-1:0] nm, np;
    @(negedge clk);
    bus.nm = ND'($urandom); bus.np = ND'($urandom); bus.sign = 1'b0; bus.one = 1'b1; bus.two = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.a !== '0 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_reset: got ir=%b ov=%b a=%h err=%b want ir=1 ov=0 a=0 err=0",
               bus.in_ready, bus.out_valid, bus.a, bus.err);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL midrun_no_out_valid: got 1 want 0"); end
    nm = ND'($urandom); np = ND'($urandom);
    run_txn(nm, np, 1'b1, 1'b0, 1'b1, a, e, lat);
    vectors++; if (a !== ref_value(nm, np, 1'b1, 1'b0, 1'b1) || lat !== LAT) begin
      miscompares++; $display("FAIL midrun_next: got a=%h lat=%0d want a=%h lat=%0d",
                              a, lat, ref_value(nm, np, 1'b1, 1'b0, 1'b1), LAT); end
    release_out();
  endtask

  task automatic test_random();
    logic [W-1:0]  x, a, exp;
    logic          e, s, o, t;
    int            lat;
    logic [ND-1:0] nm, np;
    for (int i = 0; i < 40; i++) begin
      x = W'($urandom);
      if (i == 0) x = 32'h7FFF_FFFF;
      if (i == 1) x = 32'h8000_0001;
      encode(x, nm, np, s, o, t);
      run_txn(nm, np, s, o, t, a, e, lat);
      vectors++; if (a !== x || e !== 1'b0 || lat !== LAT) begin
        miscompares++; $display("FAIL rand_enc%0d: got a=%h err=%b lat=%0d want a=%h err=0 lat=%0d",
                                i, a, e, lat, x, LAT); end
      release_out();
    end
    for (int i = 0; i < 20; i++) begin
      nm = ND'($urandom); np = ND'($urandom);
      s = 1'($urandom); o = 1'($urandom); t = 1'($urandom);
      exp = ref_value(nm, np, s, o, t);
      run_txn(nm, np, s, o, t, a, e, lat);
      vectors++; if (e !== (o & t)) begin miscompares++; $display("FAIL rand_raw%0d_err: got %b want %b", i, e, o & t); end
      if (!(o & t)) begin
        vectors++; if (a !== exp) begin miscompares++; $display("FAIL rand_raw%0d_a: got %h want %h", i, a, exp); end
      end
      release_out();
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]  a, exp;
    logic          e;
    int            lat;
    logic [ND-1:0] nm, np;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      nm = ND'($urandom); np = ND'($urandom);
      exp = ref_value(nm, np, 1'b1, 1'b1, 1'b0);
      run_txn(nm, np, 1'b1, 1'b1, 1'b0, a, e, lat);
      vectors++; if (a !== exp || lat !== LAT) begin
        miscompares++; $display("FAIL b2b%0d: got a=%h lat=%0d want a=%h lat=%0d", i, a, lat, exp, LAT); end
      @(posedge clk); #1;
      vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        miscompares++; $display("FAIL b2b%0d_bubble: got ov=%b ir=%b want ov=0 ir=1", i, bus.out_valid, bus.in_ready); end
    end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.nm = '0; bus.np = '0; bus.sign = 1'b0; bus.one = 1'b0; bus.two = 1'b0;
    test_reset();
    test_vectors();
    test_illegal();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/nr4sdm_decoder.md
NR4SDM_DECODER -- requirements
Module: nr4sdm_decoder

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 15: number of NR4SD- digit pairs preceding the final MB digit.
REQ-002 SHALL have parameter WIDTH, default 32: result width, equal to 2*NUM_DIGITS+2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  digit set on nm/np/sign/one/two is valid.
REQ-006 in_ready  output  1  decoder can accept a digit set.
REQ-007 nm  input  NUM_DIGITS  negative-weight bits; digit j weight -2*4^j.
REQ-008 np  input  NUM_DIGITS  positive-weight bits; digit j weight +1*4^j.
REQ-009 sign, one, two  input  1 each  Modified Booth most-significant digit, weight 4^NUM_DIGITS.
REQ-010 out_valid  output  1  a/err hold a completed result.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 a  output  WIDTH  reconstructed two's-complement value.
REQ-013 err  output  1  the accepted MB digit was illegal (one=1 and two=1).

Function
REQ-014 Digit j (0..NUM_DIGITS-1) SHALL have value np[j] - 2*nm[j], range {-2,-1,0,1}.
REQ-015 The MB digit SHALL have value (sign ? -1 : +1) * (one ? 1 : two ? 2 : 0); sign with zero magnitude SHALL decode as 0.
REQ-016 Result SHALL be sum of all digit values times their weights, taken modulo 2^WIDTH, so it equals the original encoder input bit-for-bit.
REQ-017 FSM states SHALL be IDLE, RUN, DONE.
REQ-018 IDLE: in_ready=1; on in_valid, SHALL register nm/np, set acc = sign-extended MB value, set counter = NUM_DIGITS-1, set err flag, go to RUN.
REQ-019 RUN: in_ready=0; each cycle SHALL compute acc = (acc<<2) + digit[counter] (Horner, MSB first) and decrement counter; after digit 0 SHALL go to DONE.
REQ-020 DONE: out_valid=1, a=acc, err stable; on out_ready SHALL return to IDLE in the next cycle.
REQ-021 Latency: out_valid SHALL assert exactly NUM_DIGITS+1 cycles after the accepting edge (16 for defaults).
REQ-022 Illegal MB code SHALL decode with magnitude 0, set err=1, and complete normally; a is don't-care when err=1.
REQ-023 out_valid low with out_ready high SHALL have no effect; out_ready low in DONE SHALL hold a/err/out_valid indefinitely.
REQ-024 Inputs SHALL be sampled only on the accepting edge; changes during RUN/DONE SHALL be ignored.
REQ-025 No back-to-back overlap: the next set is accepted only in IDLE (one cycle bubble after DONE handshake).

Reset
REQ-026 rst SHALL force state IDLE, in_ready=1, out_valid=0, a=0, err=0, counter=0, acc=0 on the next edge.
REQ-027 rst in RUN or DONE SHALL abandon the operation; no out_valid pulse SHALL follow.
REQ-028 rst SHALL dominate simultaneous in_valid or out_ready.

Structure
REQ-029 Package nr4sdm_pkg SHALL hold NUM_DIGITS, WIDTH defaults and the state encoding constants IDLE/RUN/DONE.
REQ-030 Sub-module nr4sdm_digit_dec (combinational) SHALL map (nm,np) or (sign,one,two) to a 3-bit signed digit plus illegal flag; decoder instantiates it for the MB digit and for the current RUN digit.
REQ-031 Accumulator SHALL be WIDTH bits, wrap-around arithmetic; no wider internal result is exposed.

Verification
REQ-032 nm=0, np=0, sign/one/two=0 -> a=0x00000000, err=0, out_valid at cycle 16.
REQ-033 nm=15'h0001, np=15'h0001, MB zero -> a=0xFFFFFFFF, err=0.
REQ-034 nm=0, np=0, sign=1, two=1, one=0 -> a=0x80000000; sign=0, one=1 with nm=np=0 -> a=0x40000000.
REQ-035 one=1, two=1 -> err=1 at out_valid; next transaction with legal code -> err=0.
REQ-036 out_ready held low 10 cycles in DONE -> a/out_valid stable, in_ready=0; release -> IDLE next cycle.
REQ-037 rst asserted at RUN cycle 7 -> IDLE next edge, no out_valid; new set then decodes correctly; plus random 32-bit values through a reference NR4SD- encoder model -> a equals original value.
